button_event_decoder: RTL and testbench

//  Sits between the two debounce instances and the game/counter FSM. Turns the debounced

---
 rtl/button_event_decoder.sv | 156 +++++++++++++++
 tb/tb_button_event_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// ============================================================================
// Module  : button_event_decoder
// Purpose : Debounced L/R button levels -> one-cycle short/long/repeat/chord pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_event_decoder #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       timebase,
  input  logic       button_l,
  input  logic       button_r,
  output logic       ev_l_short,
  output logic       ev_l_long,
  output logic       ev_l_rep,
  output logic       ev_r_short,
  output logic       ev_r_long,
  output logic       ev_r_rep,
  output logic       ev_chord,
  output logic [3:0] dec_state
);

  typedef enum logic [1:0] {
    ARMWAIT = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  // Index 0 is the left channel, index 1 the right channel.
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       short_q, short_d;
  logic [1:0]       long_q,  long_d;
  logic [1:0]       rep_q,   rep_d;
  logic             chord_q, chord_d;
  logic             ev_chord_q, ev_chord_d;

  logic [1:0]       btn;
  logic             chord_set;
  logic             suppress;
  logic             any_active;

  assign btn = {button_r, button_l};

  always_comb begin
    // A chord only forms while neither channel is in ARMWAIT or has already gone long.
    chord_set  = button_l && button_r &&
                 (state_q[0] == IDLE || state_q[0] == PRESSED) &&
                 (state_q[1] == IDLE || state_q[1] == PRESSED);
    suppress   = chord_q || chord_set;
    any_active = 1'b0;
    chord_d    = chord_q;
    ev_chord_d = 1'b0;
    short_d    = 2'b00;
    long_d     = 2'b00;
    rep_d      = 2'b00;

    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        ARMWAIT: begin
          if (!btn[ch]) state_d[ch] = IDLE;
        end
        IDLE: begin
          if (btn[ch]) begin
            state_d[ch] = PRESSED;
            cnt_d[ch]   = '0;
          end
        end
        PRESSED: begin
          if (!btn[ch]) begin
            state_d[ch] = IDLE;
            short_d[ch] = !suppress;
          end else if (timebase) begin
            if (cnt_q[ch] == LONG_LAST) begin
              state_d[ch] = HELD;
              cnt_d[ch]   = '0;
              long_d[ch]  = !suppress;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
        end
        HELD: begin
          if (!btn[ch]) begin
            state_d[ch] = IDLE;
          end else if (timebase) begin
            if (cnt_q[ch] == REP_LAST) begin
              cnt_d[ch] = '0;
              rep_d[ch] = !suppress;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
        end
      endcase
      if (state_d[ch] == PRESSED || state_d[ch] == HELD) any_active = 1'b1;
    end

    // Looking at next state lets the chord pulse land one clock after the last release.
    if (chord_q && !any_active) begin
      chord_d    = 1'b0;
      ev_chord_d = 1'b1;
    end else if (chord_set) begin
      chord_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ARMWAIT;
        cnt_q[ch]   <= '0;
      end
      short_q    <= 2'b00;
      long_q     <= 2'b00;
      rep_q      <= 2'b00;
      chord_q    <= 1'b0;
      ev_chord_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      short_q    <= short_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
      chord_q    <= chord_d;
      ev_chord_q <= ev_chord_d;
    end
  end

  assign ev_l_short = short_q[0];
  assign ev_l_long  = long_q[0];
  assign ev_l_rep   = rep_q[0];
  assign ev_r_short = short_q[1];
  assign ev_r_long  = long_q[1];
  assign ev_r_rep   = rep_q[1];
  assign ev_chord   = ev_chord_q;
  assign dec_state  = {state_q[1], state_q[0]};

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// ============================================================================
// Module  : tb_button_event_decoder
// Purpose : Directed bench for button_event_decoder (LONG=10, REPEAT=4, tick every 10 clk).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_event_decoder;

  logic       clk;
  logic       reset_n;
  logic       timebase;
  logic       button_l;
  logic       button_r;
  logic       ev_l_short, ev_l_long, ev_l_rep;
  logic       ev_r_short, ev_r_long, ev_r_rep;
  logic       ev_chord;
  logic [3:0] dec_state;

  int n_checks;
  int n_errors;
  int n_ls, n_ll, n_lr, n_rs, n_rl, n_rr, n_ch;

  button_event_decoder #(
    .LONG_TICKS  (10),
    .REPEAT_TICKS(4),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .timebase  (timebase),
    .button_l  (button_l),
    .button_r  (button_r),
    .ev_l_short(ev_l_short),
    .ev_l_long (ev_l_long),
    .ev_l_rep  (ev_l_rep),
    .ev_r_short(ev_r_short),
    .ev_r_long (ev_r_long),
    .ev_r_rep  (ev_r_rep),
    .ev_chord  (ev_chord),
    .dec_state (dec_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_ls = 0; n_ll = 0; n_lr = 0; n_rs = 0; n_rl = 0; n_rr = 0; n_ch = 0;
  endtask

  // One clock; outputs are sampled 1 ns after the edge that produced them.
  task automatic cyc();
    @(posedge clk);
    #1;
    n_ls += int'(ev_l_short); n_ll += int'(ev_l_long); n_lr += int'(ev_l_rep);
    n_rs += int'(ev_r_short); n_rl += int'(ev_r_long); n_rr += int'(ev_r_rep);
    n_ch += int'(ev_chord);
  endtask

  // Nine quiet clocks then one clock with timebase high.
  task automatic tick();
    timebase = 1'b0;
    repeat (9) cyc();
    timebase = 1'b1;
    cyc();
    timebase = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_counts();
    reset_n  = 1'b0;
    timebase = 1'b0;
    button_l = 1'b0;
    button_r = 1'b0;
    #1;
    check("rst_dec_state", 32'(dec_state), 32'h0);
    check("rst_events", 32'({ev_l_short, ev_l_long, ev_l_rep, ev_r_short, ev_r_long, ev_r_rep, ev_chord}), 32'h0);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    check("arm_to_idle", 32'(dec_state), 32'h5);

    // Short press on L
    clear_counts();
    button_l = 1'b1;
    cyc();
    check("l_pressed_state", 32'(dec_state), 32'h6);
    repeat (3) tick();
    button_l = 1'b0;
    cyc();
    check("l_short_latency", 32'(ev_l_short), 32'd1);
    check("l_short_idle", 32'(dec_state), 32'h5);
    cyc();
    check("l_short_oneshot", 32'(ev_l_short), 32'd0);
    check("l_short_count", 32'(n_ls), 32'd1);
    check("l_short_no_long_rep", 32'(n_ll + n_lr), 32'd0);

    // Long press on L with repeats
    clear_counts();
    button_l = 1'b1;
    cyc();
    repeat (9) tick();
    check("l_no_long_before_10", 32'(n_ll), 32'd0);
    tick();
    check("l_long_at_10", 32'(ev_l_long), 32'd1);
    check("l_held_state", 32'(dec_state), 32'h7);
    repeat (3) tick();
    check("l_no_rep_before_14", 32'(n_lr), 32'd0);
    tick();
    check("l_rep_at_14", 32'(ev_l_rep), 32'd1);
    repeat (3) tick();
    check("l_rep_count_17", 32'(n_lr), 32'd1);
    tick();
    check("l_rep_at_18", 32'(ev_l_rep), 32'd1);
    repeat (2) tick();
    button_l = 1'b0;
    repeat (2) cyc();
    check("l_long_count", 32'(n_ll), 32'd1);
    check("l_rep_count", 32'(n_lr), 32'd2);
    check("l_held_release_no_short", 32'(n_ls), 32'd0);
    check("l_long_no_chord", 32'(n_ch), 32'd0);

    // Chord: both pressed together, R released first, then L
    clear_counts();
    button_l = 1'b1;
    button_r = 1'b1;
    cyc();
    repeat (15) tick();
    button_r = 1'b0;
    repeat (2) cyc();
    check("chord_not_yet", 32'(n_ch), 32'd0);
    button_l = 1'b0;
    cyc();
    check("chord_latency", 32'(ev_chord), 32'd1);
    cyc();
    check("chord_oneshot", 32'(ev_chord), 32'd0);
    check("chord_count", 32'(n_ch), 32'd1);
    check("chord_suppress", 32'(n_ls + n_ll + n_lr + n_rs + n_rl + n_rr), 32'd0);
    check("chord_idle", 32'(dec_state), 32'h5);

    // R held through reset deassert
    clear_counts();
    button_r = 1'b1;
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    check("r_armwait", 32'(dec_state), 32'h1);
    repeat (3) tick();
    button_r = 1'b0;
    repeat (2) cyc();
    check("r_first_release_silent", 32'(n_rs + n_rl + n_rr + n_ch), 32'd0);
    check("r_armed_idle", 32'(dec_state), 32'h5);
    button_r = 1'b1;
    cyc();
    repeat (2) tick();
    button_r = 1'b0;
    cyc();
    check("r_short_latency", 32'(ev_r_short), 32'd1);
    cyc();
    check("r_short_count", 32'(n_rs), 32'd1);

    // L release coincident with its 10th tick
    clear_counts();
    button_l = 1'b1;
    cyc();
    repeat (9) tick();
    repeat (9) cyc();
    timebase = 1'b1;
    button_l = 1'b0;
    cyc();
    timebase = 1'b0;
    check("coinc_short", 32'(ev_l_short), 32'd1);
    check("coinc_no_long", 32'(ev_l_long), 32'd0);
    repeat (2) cyc();
    check("coinc_counts", 32'(n_ls * 16 + n_ll), 32'd16);

    // Reset while L in HELD
    clear_counts();
    button_l = 1'b1;
    cyc();
    repeat (10) tick();
    check("pre_reset_long", 32'(ev_l_long), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_long", 32'(ev_l_long), 32'd0);
    check("async_reset_state", 32'(dec_state), 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    check("post_reset_state", 32'(dec_state), 32'h4);
    clear_counts();
    repeat (12) tick();
    check("post_reset_silent", 32'(n_ls + n_ll + n_lr), 32'd0);
    button_l = 1'b0;
    cyc();
    check("post_reset_armed", 32'(dec_state), 32'h5);
    button_l = 1'b1;
    cyc();
    repeat (2) tick();
    button_l = 1'b0;
    cyc();
    check("post_reset_short", 32'(ev_l_short), 32'd1);
    cyc();
    check("post_reset_counts", 32'(n_ls * 16 + n_ll + n_lr), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
